// File: rtl/character_position_file.sv
// -----------------------------------------------------------------------------
// character_position_file
//
// Holds the tile position of every character in the game: slot 0 is pacman,
// slots 1..NUM_CHARS-1 are ghosts. One command is processed at a time through
// a small IDLE -> EXEC -> RESP handshake. Supported operations are read, write
// (range checked), move (x wraps around the maze, y saturates at the walls)
// and home (return the slot to its start tile).
//
// Optional feature macro: CHARPOS_COLLIDE_EN
//   defined   : collide_mask is refreshed one cycle after every slot write,
//               bit i set when ghost i sits on pacman's tile.
//   undefined : collide_mask is tied to zero.
//
// Ports
//   clock_50      in   system clock, rising edge
//   reset_n       in   asynchronous active-low reset
//   cmd_valid     in   command offered
//   cmd_ready     out  command may be accepted (IDLE only)
//   cmd_op        in   00 read, 01 write, 10 move, 11 home
//   cmd_id        in   target slot
//   cmd_x, cmd_y  in   write data
//   cmd_dir       in   00 up, 01 right, 10 down, 11 left
//   rsp_valid     out  response available
//   rsp_ready     in   response consumed
//   rsp_x, rsp_y  out  slot position after the command
//   rsp_id        out  echo of the command id
//   rsp_err       out  command rejected
//   collide_mask  out  per-ghost collision flags (bit 0 always 0)
// -----------------------------------------------------------------------------
module character_position_file #(
    parameter  int NUM_CHARS = 5,
    parameter  int COORD_W   = 5,
    parameter  int X_MAX     = 20,
    parameter  int Y_MAX     = 20,
    parameter  int RESET_X   = 2,
    parameter  int RESET_Y   = 2,
    localparam int ID_W      = (NUM_CHARS > 1) ? $clog2(NUM_CHARS) : 1
) (
    input  logic                 clock_50,
    input  logic                 reset_n,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [1:0]           cmd_op,
    input  logic [ID_W-1:0]      cmd_id,
    input  logic [COORD_W-1:0]   cmd_x,
    input  logic [COORD_W-1:0]   cmd_y,
    input  logic [1:0]           cmd_dir,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [COORD_W-1:0]   rsp_x,
    output logic [COORD_W-1:0]   rsp_y,
    output logic [ID_W-1:0]      rsp_id,
    output logic                 rsp_err,
    output logic [NUM_CHARS-1:0] collide_mask
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXEC,
        ST_RESP
    } state_t;

    localparam logic [1:0] OP_READ  = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_MOVE  = 2'b10;
    localparam logic [1:0] OP_HOME  = 2'b11;

    localparam logic [1:0] DIR_UP    = 2'b00;
    localparam logic [1:0] DIR_RIGHT = 2'b01;
    localparam logic [1:0] DIR_DOWN  = 2'b10;
    localparam logic [1:0] DIR_LEFT  = 2'b11;

    // All coordinate arithmetic is done one bit wider than storage.
    localparam logic [COORD_W:0]   X_MAX_E   = (COORD_W+1)'(X_MAX);
    localparam logic [COORD_W:0]   Y_MAX_E   = (COORD_W+1)'(Y_MAX);
    localparam logic [COORD_W:0]   RESET_X_E = (COORD_W+1)'(RESET_X);
    localparam logic [COORD_W:0]   RESET_Y_E = (COORD_W+1)'(RESET_Y);
    localparam logic [COORD_W:0]   ONE_E     = (COORD_W+1)'(1);
    localparam logic [COORD_W-1:0] RESET_X_C = COORD_W'(RESET_X);
    localparam logic [COORD_W-1:0] RESET_Y_C = COORD_W'(RESET_Y);
    localparam logic [ID_W:0]      NUM_E     = (ID_W+1)'(NUM_CHARS);

    state_t state, state_next;

    logic [1:0]         op_q;
    logic [ID_W-1:0]    id_q;
    logic [COORD_W-1:0] x_q;
    logic [COORD_W-1:0] y_q;
    logic [1:0]         dir_q;

    logic [COORD_W-1:0] pos_x [NUM_CHARS];
    logic [COORD_W-1:0] pos_y [NUM_CHARS];

    logic               id_ok;
    logic [ID_W-1:0]    safe_id;
    logic [COORD_W:0]   cur_x, cur_y, wr_x, wr_y;
    logic [COORD_W:0]   exec_x, exec_y;
    logic               exec_err, exec_wr;

    // State register.
    always_ff @(posedge clock_50 or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: a single EXEC cycle, then hold RESP until consumed.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (cmd_valid) state_next = ST_EXEC;
            ST_EXEC: state_next = ST_RESP;
            ST_RESP: if (rsp_ready) state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Handshake outputs decoded straight from the state.
    always_comb begin
        cmd_ready = (state == ST_IDLE);
        rsp_valid = (state == ST_RESP);
    end

    // Capture the command on acceptance; later offers are ignored until IDLE.
    always_ff @(posedge clock_50 or negedge reset_n) begin
        if (!reset_n) begin
            op_q  <= '0;
            id_q  <= '0;
            x_q   <= '0;
            y_q   <= '0;
            dir_q <= '0;
        end else if (state == ST_IDLE && cmd_valid) begin
            op_q  <= cmd_op;
            id_q  <= cmd_id;
            x_q   <= cmd_x;
            y_q   <= cmd_y;
            dir_q <= cmd_dir;
        end
    end

    // An out-of-range id must never index the slot arrays, so it is parked on 0.
    assign id_ok   = ({1'b0, id_q} < NUM_E);
    assign safe_id = id_ok ? id_q : '0;
    assign cur_x   = {1'b0, pos_x[safe_id]};
    assign cur_y   = {1'b0, pos_y[safe_id]};
    assign wr_x    = {1'b0, x_q};
    assign wr_y    = {1'b0, y_q};

    // Position update computed during EXEC. x wraps so characters can use the
    // side tunnel; y saturates because the top and bottom are solid walls.
    always_comb begin
        exec_x   = cur_x;
        exec_y   = cur_y;
        exec_err = 1'b0;
        exec_wr  = 1'b0;
        if (!id_ok) begin
            exec_x   = '0;
            exec_y   = '0;
            exec_err = 1'b1;
        end else begin
            case (op_q)
                OP_READ: begin
                end
                OP_WRITE: begin
                    if (wr_x > X_MAX_E || wr_y > Y_MAX_E) begin
                        exec_err = 1'b1;
                    end else begin
                        exec_x  = wr_x;
                        exec_y  = wr_y;
                        exec_wr = 1'b1;
                    end
                end
                OP_MOVE: begin
                    exec_wr = 1'b1;
                    case (dir_q)
                        DIR_UP:    if (cur_y != '0)     exec_y = cur_y - ONE_E;
                        DIR_DOWN:  if (cur_y < Y_MAX_E) exec_y = cur_y + ONE_E;
                        DIR_RIGHT: exec_x = (cur_x >= X_MAX_E) ? '0 : cur_x + ONE_E;
                        DIR_LEFT:  exec_x = (cur_x == '0) ? X_MAX_E : cur_x - ONE_E;
                        default: begin
                        end
                    endcase
                end
                OP_HOME: begin
                    exec_x  = RESET_X_E;
                    exec_y  = RESET_Y_E;
                    exec_wr = 1'b1;
                end
                default: begin
                end
            endcase
            // A result that would not fit the stored width is refused rather
            // than truncated.
            if (exec_x[COORD_W] || exec_y[COORD_W]) begin
                exec_x   = cur_x;
                exec_y   = cur_y;
                exec_err = 1'b1;
                exec_wr  = 1'b0;
            end
        end
    end

    // Slot storage and response registers, both updated at the end of EXEC.
    always_ff @(posedge clock_50 or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_CHARS; i++) begin
                pos_x[i] <= RESET_X_C;
                pos_y[i] <= RESET_Y_C;
            end
            rsp_x   <= '0;
            rsp_y   <= '0;
            rsp_id  <= '0;
            rsp_err <= 1'b0;
        end else if (state == ST_EXEC) begin
            rsp_x   <= exec_x[COORD_W-1:0];
            rsp_y   <= exec_y[COORD_W-1:0];
            rsp_id  <= id_q;
            rsp_err <= exec_err;
            if (exec_wr) begin
                pos_x[safe_id] <= exec_x[COORD_W-1:0];
                pos_y[safe_id] <= exec_y[COORD_W-1:0];
            end
        end
    end

`ifdef CHARPOS_COLLIDE_EN
    logic                 wr_pulse;
    logic [NUM_CHARS-1:0] collide_q;

    // The mask is re-evaluated the cycle after a write so it sees the new slot.
    always_ff @(posedge clock_50 or negedge reset_n) begin
        if (!reset_n) begin
            wr_pulse  <= 1'b0;
            collide_q <= '0;
        end else begin
            wr_pulse <= (state == ST_EXEC) && exec_wr;
            if (wr_pulse) begin
                collide_q[0] <= 1'b0;
                for (int i = 1; i < NUM_CHARS; i++) begin
                    collide_q[i] <= (pos_x[i] == pos_x[0]) && (pos_y[i] == pos_y[0]);
                end
            end
        end
    end

    assign collide_mask = collide_q;
`else
    assign collide_mask = '0;
`endif

endmodule

// File: tb/tb_character_position_file.sv
// -----------------------------------------------------------------------------
// tb_character_position_file
//
// Self-checking bench for character_position_file with default parameters.
// Expected responses come from a small behavioural model of the slot file,
// pushed onto a scoreboard queue when each command is driven and popped when
// the response handshake completes.
// -----------------------------------------------------------------------------
module tb_character_position_file;

    localparam int NC = 5;

    logic       clock_50 = 1'b0;
    logic       reset_n  = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [1:0] cmd_op   = '0;
    logic [2:0] cmd_id   = '0;
    logic [4:0] cmd_x    = '0;
    logic [4:0] cmd_y    = '0;
    logic [1:0] cmd_dir  = '0;
    logic       rsp_valid;
    logic       rsp_ready = 1'b0;
    logic [4:0] rsp_x;
    logic [4:0] rsp_y;
    logic [2:0] rsp_id;
    logic       rsp_err;
    logic [4:0] collide_mask;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int x;
        int y;
        int id;
        int err;
    } exp_t;

    typedef struct {
        int op;
        int id;
        int x;
        int y;
        int dir;
    } cmd_t;

    exp_t sb_q[$];
    int   model_x[NC];
    int   model_y[NC];

    character_position_file dut (
        .clock_50     (clock_50),
        .reset_n      (reset_n),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_op       (cmd_op),
        .cmd_id       (cmd_id),
        .cmd_x        (cmd_x),
        .cmd_y        (cmd_y),
        .cmd_dir      (cmd_dir),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_x        (rsp_x),
        .rsp_y        (rsp_y),
        .rsp_id       (rsp_id),
        .rsp_err      (rsp_err),
        .collide_mask (collide_mask)
    );

    always #10 clock_50 = ~clock_50;

    // Behavioural reference: X_MAX = Y_MAX = 20, home = (2,2).
    function automatic exp_t model_apply(input cmd_t c);
        exp_t e;
        e.id  = c.id;
        e.err = 0;
        if (c.id >= NC) begin
            e.x = 0;
            e.y = 0;
            e.err = 1;
            return e;
        end
        case (c.op)
            1: begin
                if (c.x > 20 || c.y > 20) e.err = 1;
                else begin
                    model_x[c.id] = c.x;
                    model_y[c.id] = c.y;
                end
            end
            2: begin
                case (c.dir)
                    0: model_y[c.id] = (model_y[c.id] == 0) ? 0 : model_y[c.id] - 1;
                    1: model_x[c.id] = (model_x[c.id] == 20) ? 0 : model_x[c.id] + 1;
                    2: model_y[c.id] = (model_y[c.id] == 20) ? 20 : model_y[c.id] + 1;
                    default: model_x[c.id] = (model_x[c.id] == 0) ? 20 : model_x[c.id] - 1;
                endcase
            end
            3: begin
                model_x[c.id] = 2;
                model_y[c.id] = 2;
            end
            default: begin
            end
        endcase
        e.x = model_x[c.id];
        e.y = model_y[c.id];
        return e;
    endfunction

    // Drives one command, waits for its response, consumes it and reports
    // what came back plus the number of edges after acceptance until valid.
    task automatic send_cmd(input cmd_t c, output exp_t got, output int lat);
        int w;
        @(negedge clock_50);
        cmd_op    = c.op[1:0];
        cmd_id    = c.id[2:0];
        cmd_x     = c.x[4:0];
        cmd_y     = c.y[4:0];
        cmd_dir   = c.dir[1:0];
        cmd_valid = 1'b1;
        w = 0;
        while (!cmd_ready && w < 20) begin
            @(negedge clock_50);
            w++;
        end
        checks++;
        if (!cmd_ready) begin
            failures++;
            $display("[TB] FAIL accept_timeout: cmd_ready=%0b required 1", cmd_ready);
        end
        @(posedge clock_50);
        #1 cmd_valid = 1'b0;
        lat = 0;
        while (!rsp_valid && lat < 10) begin
            @(posedge clock_50);
            #1 lat++;
        end
        got.x   = rsp_x;
        got.y   = rsp_y;
        got.id  = rsp_id;
        got.err = rsp_err;
        @(negedge clock_50);
        rsp_ready = 1'b1;
        @(posedge clock_50);
        #1 rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        for (int i = 0; i < NC; i++) begin
            model_x[i] = 2;
            model_y[i] = 2;
        end
        reset_n = 1'b0;
        repeat (3) @(posedge clock_50);
        @(negedge clock_50);
        checks++;
        if (rsp_valid !== 1'b0 || rsp_err !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_flags: valid=%0b err=%0b required 0 0", rsp_valid, rsp_err);
        end
        checks++;
        if (rsp_x !== 5'd0 || rsp_y !== 5'd0 || rsp_id !== 3'd0) begin
            failures++;
            $display("[TB] FAIL reset_data: x=%0d y=%0d id=%0d required 0 0 0", rsp_x, rsp_y, rsp_id);
        end
        checks++;
        if (collide_mask !== 5'd0) begin
            failures++;
            $display("[TB] FAIL reset_mask: got %b required 00000", collide_mask);
        end
        reset_n = 1'b1;
        @(negedge clock_50);
        checks++;
        if (cmd_ready !== 1'b1) begin
            failures++;
            $display("[TB] FAIL reset_ready: got %0b required 1", cmd_ready);
        end
    endtask

    task automatic test_read_after_reset();
        cmd_t c;
        exp_t got, e;
        int   lat;
        c = '{0, 3, 0, 0, 0};
        sb_q.push_back(model_apply(c));
        send_cmd(c, got, lat);
        e = sb_q.pop_front();
        checks++;
        if (lat !== 1) begin
            failures++;
            $display("[TB] FAIL read_latency: got %0d extra edges required 1", lat);
        end
        checks++;
        if (got.x !== e.x || got.y !== e.y || got.id !== e.id || got.err !== e.err) begin
            failures++;
            $display("[TB] FAIL read_reset: got (%0d,%0d) id=%0d err=%0d required (%0d,%0d) id=%0d err=%0d",
                     got.x, got.y, got.id, got.err, e.x, e.y, e.id, e.err);
        end
    endtask

    task automatic test_write();
        cmd_t tbl[4];
        exp_t got, e;
        int   lat;
        tbl[0] = '{1, 1, 7, 9, 0};
        tbl[1] = '{0, 1, 0, 0, 0};
        tbl[2] = '{1, 1, 21, 0, 0};
        tbl[3] = '{0, 1, 0, 0, 0};
        for (int i = 0; i < 4; i++) begin
            sb_q.push_back(model_apply(tbl[i]));
            send_cmd(tbl[i], got, lat);
            e = sb_q.pop_front();
            checks++;
            if (got.x !== e.x || got.y !== e.y || got.id !== e.id || got.err !== e.err || lat !== 1) begin
                failures++;
                $display("[TB] FAIL write_%0d: got (%0d,%0d) id=%0d err=%0d lat=%0d required (%0d,%0d) id=%0d err=%0d lat=1",
                         i, got.x, got.y, got.id, got.err, lat, e.x, e.y, e.id, e.err);
            end
        end
    endtask

    task automatic test_move();
        cmd_t tbl[8];
        exp_t got, e;
        int   lat;
        tbl[0] = '{1, 0, 0, 5, 0};
        tbl[1] = '{2, 0, 0, 0, 3};
        tbl[2] = '{2, 0, 0, 0, 1};
        tbl[3] = '{1, 0, 4, 0, 0};
        tbl[4] = '{2, 0, 0, 0, 0};
        tbl[5] = '{1, 3, 5, 20, 0};
        tbl[6] = '{2, 3, 0, 0, 2};
        tbl[7] = '{3, 3, 0, 0, 0};
        for (int i = 0; i < 8; i++) begin
            sb_q.push_back(model_apply(tbl[i]));
            send_cmd(tbl[i], got, lat);
            e = sb_q.pop_front();
            checks++;
            if (got.x !== e.x || got.y !== e.y || got.id !== e.id || got.err !== e.err || lat !== 1) begin
                failures++;
                $display("[TB] FAIL move_%0d: got (%0d,%0d) id=%0d err=%0d lat=%0d required (%0d,%0d) id=%0d err=%0d lat=1",
                         i, got.x, got.y, got.id, got.err, lat, e.x, e.y, e.id, e.err);
            end
        end
    endtask

    // Reads every slot back and compares against the model.
    task automatic test_all_slots(input string tag);
        cmd_t c;
        exp_t got, e;
        int   lat;
        for (int i = 0; i < NC; i++) begin
            c = '{0, i, 0, 0, 0};
            sb_q.push_back(model_apply(c));
            send_cmd(c, got, lat);
            e = sb_q.pop_front();
            checks++;
            if (got.x !== e.x || got.y !== e.y || got.err !== e.err) begin
                failures++;
                $display("[TB] FAIL %s_slot%0d: got (%0d,%0d) err=%0d required (%0d,%0d) err=%0d",
                         tag, i, got.x, got.y, got.err, e.x, e.y, e.err);
            end
        end
    endtask

    task automatic test_bad_id();
        cmd_t c;
        exp_t got, e;
        int   lat;
        c = '{1, 6, 1, 1, 0};
        sb_q.push_back(model_apply(c));
        send_cmd(c, got, lat);
        e = sb_q.pop_front();
        checks++;
        if (got.x !== e.x || got.y !== e.y || got.id !== e.id || got.err !== e.err) begin
            failures++;
            $display("[TB] FAIL bad_id: got (%0d,%0d) id=%0d err=%0d required (%0d,%0d) id=%0d err=%0d",
                     got.x, got.y, got.id, got.err, e.x, e.y, e.id, e.err);
        end
        test_all_slots("bad_id");
    endtask

    task automatic test_backpressure();
        cmd_t c;
        exp_t e;
        int   lat;
        logic stable_ok;
        c = '{0, 1, 0, 0, 0};
        sb_q.push_back(model_apply(c));
        @(negedge clock_50);
        cmd_op = 2'b00;
        cmd_id = 3'd1;
        cmd_valid = 1'b1;
        @(posedge clock_50);
        #1 cmd_valid = 1'b0;
        lat = 0;
        while (!rsp_valid && lat < 10) begin
            @(posedge clock_50);
            #1 lat++;
        end
        e = sb_q.pop_front();
        // A competing write is offered while the response is held; it must be ignored.
        cmd_op = 2'b01;
        cmd_id = 3'd4;
        cmd_x  = 5'd9;
        cmd_y  = 5'd9;
        cmd_valid = 1'b1;
        stable_ok = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clock_50);
            #1;
            if (rsp_valid !== 1'b1 || cmd_ready !== 1'b0 || rsp_x !== e.x[4:0] ||
                rsp_y !== e.y[4:0] || rsp_err !== 1'b0 || rsp_id !== 3'd1)
                stable_ok = 1'b0;
        end
        checks++;
        if (stable_ok !== 1'b1) begin
            failures++;
            $display("[TB] FAIL hold_stable: valid=%0b ready=%0b (%0d,%0d) required 1 0 (%0d,%0d)",
                     rsp_valid, cmd_ready, rsp_x, rsp_y, e.x, e.y);
        end
        @(negedge clock_50);
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clock_50);
        #1 rsp_ready = 1'b0;
        test_all_slots("ignored_cmd");
    endtask

    task automatic test_reset_in_exec();
        logic saw_valid;
        @(negedge clock_50);
        cmd_op = 2'b01;
        cmd_id = 3'd2;
        cmd_x  = 5'd5;
        cmd_y  = 5'd5;
        cmd_valid = 1'b1;
        @(posedge clock_50);
        #1 cmd_valid = 1'b0;
        reset_n = 1'b0;
        for (int i = 0; i < NC; i++) begin
            model_x[i] = 2;
            model_y[i] = 2;
        end
        saw_valid = 1'b0;
        repeat (2) begin
            @(negedge clock_50);
            if (rsp_valid !== 1'b0) saw_valid = 1'b1;
        end
        reset_n = 1'b1;
        repeat (4) begin
            @(negedge clock_50);
            if (rsp_valid !== 1'b0) saw_valid = 1'b1;
        end
        checks++;
        if (saw_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL exec_reset_rsp: rsp_valid seen=%0b required 0", saw_valid);
        end
        test_all_slots("exec_reset");
    endtask

    task automatic test_collide();
        cmd_t tbl[3];
        logic [4:0] want[3];
        exp_t got;
        int   lat;
        tbl[0] = '{1, 0, 8, 8, 0};
        tbl[1] = '{1, 2, 8, 8, 0};
        tbl[2] = '{2, 2, 0, 0, 1};
        want[0] = 5'b00000;
`ifdef CHARPOS_COLLIDE_EN
        want[1] = 5'b00100;
`else
        want[1] = 5'b00000;
`endif
        want[2] = 5'b00000;
        for (int i = 0; i < 3; i++) begin
            sb_q.push_back(model_apply(tbl[i]));
            send_cmd(tbl[i], got, lat);
            void'(sb_q.pop_front());
            checks++;
            if (collide_mask !== want[i]) begin
                failures++;
                $display("[TB] FAIL collide_%0d: got %b required %b", i, collide_mask, want[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_read_after_reset();
        test_write();
        test_move();
        test_bad_id();
        test_backpressure();
        test_reset_in_exec();
        test_collide();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
